// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Each master gets one latched access at a time; completions are counted per master.
module onchip_ram_arbiter #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BE_W    = DATA_W / 8,
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic [15:0]       m0_count,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [15:0]       m1_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    output logic              ram_reset_req,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, READ_DATA} state_t;

    state_t              state, state_next;
    logic                owner, owner_next;
    logic                prio, prio_next;
    logic                cmd_write, cmd_write_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic [BE_W-1:0]     be, be_next;
    logic [DATA_W-1:0]   wdata, wdata_next;
    logic [15:0]         count0, count0_next;
    logic [15:0]         count1, count1_next;
    logic                req0, req1, grant, done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            prio      <= 1'b0;
            cmd_write <= 1'b0;
            addr      <= '0;
            be        <= '0;
            wdata     <= '0;
            count0    <= '0;
            count1    <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            prio      <= prio_next;
            cmd_write <= cmd_write_next;
            addr      <= addr_next;
            be        <= be_next;
            wdata     <= wdata_next;
            count0    <= count0_next;
            count1    <= count1_next;
        end
    end

    always_comb begin
        state_next     = state;
        owner_next     = owner;
        prio_next      = prio;
        cmd_write_next = cmd_write;
        addr_next      = addr;
        be_next        = be;
        wdata_next     = wdata;
        count0_next    = count0;
        count1_next    = count1;
        done           = 1'b0;
        req0           = m0_read | m0_write;
        req1           = m1_read | m1_write;
        // prio names the master that wins a tie: the one not served last
        grant          = req1 & (~req0 | prio);

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_next     = grant;
                    cmd_write_next = grant ? m1_write      : m0_write;
                    addr_next      = grant ? m1_address    : m0_address;
                    be_next        = grant ? m1_byteenable : m0_byteenable;
                    wdata_next     = grant ? m1_writedata  : m0_writedata;
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                if (cmd_write) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = READ_DATA;
                end
            end
            READ_DATA: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (done) begin
            prio_next = ~owner;
            if (owner) begin
                if (count1 != CNT_MAX) count1_next = count1 + 16'd1;
            end else begin
                if (count0 != CNT_MAX) count0_next = count0 + 16'd1;
            end
        end
    end

    logic complete;
    assign complete = ((state == ACCESS) && cmd_write) || (state == READ_DATA);

    assign ram_address    = addr;
    assign ram_byteenable = be;
    assign ram_writedata  = wdata;
    assign ram_chipselect = (state == ACCESS);
    assign ram_write      = (state == ACCESS) && cmd_write;
    assign ram_clken      = 1'b1;
    assign ram_reset_req  = ~reset_n;

    assign m0_waitrequest = ~(complete && !owner);
    assign m1_waitrequest = ~(complete && owner);
    assign m0_readdata    = (state == READ_DATA && !owner) ? ram_readdata : '0;
    assign m1_readdata    = (state == READ_DATA && owner)  ? ram_readdata : '0;
    assign m0_count       = count0;
    assign m1_count       = count1;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus a RAM model,
// compared against the DUT every cycle, with directed scenarios and random traffic.
module tb_onchip_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam logic [15:0] CMAX = 16'd300;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr_i [2];
    logic [BW-1:0] be_i   [2];
    logic          rd_i   [2];
    logic          wr_i   [2];
    logic [DW-1:0] wd_i   [2];
    logic [DW-1:0] rdata_o[2];
    logic          wait_o [2];
    logic [15:0]   cnt_o  [2];

    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [15:0]   m0_count, m1_count;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic          ram_chipselect, ram_write, ram_clken, ram_reset_req;
    logic [DW-1:0] ram_writedata;
    logic [DW-1:0] ram_rd;

    onchip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .CNT_MAX(CMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(addr_i[0]), .m0_byteenable(be_i[0]), .m0_read(rd_i[0]), .m0_write(wr_i[0]),
        .m0_writedata(wd_i[0]), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m0_count(m0_count),
        .m1_address(addr_i[1]), .m1_byteenable(be_i[1]), .m1_read(rd_i[1]), .m1_write(wr_i[1]),
        .m1_writedata(wd_i[1]), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .m1_count(m1_count),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_clken(ram_clken), .ram_reset_req(ram_reset_req), .ram_readdata(ram_rd)
    );

    assign rdata_o[0] = m0_readdata;
    assign rdata_o[1] = m1_readdata;
    assign wait_o[0]  = m0_waitrequest;
    assign wait_o[1]  = m1_waitrequest;
    assign cnt_o[0]   = m0_count;
    assign cnt_o[1]   = m1_count;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM instance model: one-cycle read latency, gated by clken and reset_req
    logic [DW-1:0] ram_mem [16384];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (ram_chipselect && ram_clken && !ram_reset_req) begin
            if (ram_write) begin
                w = ram_mem[ram_address];
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) w[8*b +: 8] = ram_writedata[8*b +: 8];
                ram_mem[ram_address] <= w;
            end else begin
                ram_rd <= ram_mem[ram_address];
            end
        end
    end

    // Transaction-level reference: one outstanding access, its phase, and the memory it implies
    logic [DW-1:0] ref_mem [16384];
    bit            mvalid = 0;
    bit            mb;
    int            mo;
    int            mlast;
    bit            mwr;
    bit            mph;
    logic [AW-1:0] maddr;
    logic [BW-1:0] mbe;
    logic [DW-1:0] mwd;
    int unsigned   mcnt [2];
    bit            done [2];
    int            grants[$];

    always @(posedge clk) begin
        bit r0, r1;
        done[0] = 0;
        done[1] = 0;
        r0 = rd_i[0] | wr_i[0];
        r1 = rd_i[1] | wr_i[1];
        if (!reset_n) begin
            mvalid = 1; mb = 0; mlast = 1; mcnt[0] = 0; mcnt[1] = 0;
        end else if (mb) begin
            if (mwr || mph) begin
                if (mwr)
                    for (int b = 0; b < BW; b++)
                        if (mbe[b]) ref_mem[maddr][8*b +: 8] = mwd[8*b +: 8];
                if (mcnt[mo] < CMAX) mcnt[mo]++;
                mlast = mo; done[mo] = 1; mb = 0;
            end else begin
                mph = 1;
            end
        end else if (r0 || r1) begin
            if (r0 && r1) mo = 1 - mlast;
            else          mo = r1 ? 1 : 0;
            mb = 1; mph = 0;
            mwr = wr_i[mo]; maddr = addr_i[mo]; mbe = be_i[mo]; mwd = wd_i[mo];
            grants.push_back(mo);
        end
    end

    logic [DW-1:0] cap_rd [2];
    always @(negedge clk) begin
        bit e_cs, own, e_w;
        if (mvalid) begin
            e_cs = mb && !mph;
            chk("ram_chipselect", ram_chipselect, e_cs);
            chk("ram_write", ram_write, e_cs && mwr);
            chk("ram_clken", ram_clken, 1);
            chk("ram_reset_req", ram_reset_req, !reset_n);
            if (e_cs) begin
                chk("ram_address", ram_address, maddr);
                chk("ram_byteenable", ram_byteenable, mbe);
                if (mwr) chk("ram_writedata", ram_writedata, mwd);
            end
            for (int n = 0; n < 2; n++) begin
                own = mb && (mo == n);
                e_w = !(own && (mph || mwr));
                chk($sformatf("m%0d_waitrequest", n), wait_o[n], e_w);
                chk($sformatf("m%0d_readdata", n), rdata_o[n], (own && mph) ? ref_mem[maddr] : 32'h0);
                chk($sformatf("m%0d_count", n), cnt_o[n], mcnt[n]);
                if (own && mph) cap_rd[n] = rdata_o[n];
            end
        end
    end

    // Master drivers for free-running traffic; a master re-issues after each completion
    bit            auto_en [2];
    bit            auto_rand;
    logic [AW-1:0] fix_addr [2];
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 2; n++) begin
            if (auto_en[n]) begin
                if (done[n] || !(rd_i[n] | wr_i[n])) begin
                    if (!auto_rand) begin
                        rd_i[n] = 1; wr_i[n] = 0; addr_i[n] = fix_addr[n];
                    end else if ($urandom_range(3) == 0) begin
                        rd_i[n] = 0; wr_i[n] = 0;
                    end else begin
                        case ($urandom_range(2))
                            0:       begin rd_i[n] = 1; wr_i[n] = 0; end
                            1:       begin rd_i[n] = 0; wr_i[n] = 1; end
                            default: begin rd_i[n] = 1; wr_i[n] = 1; end
                        endcase
                        addr_i[n] = AW'($urandom_range(15));
                        be_i[n]   = BW'($urandom_range(15));
                        wd_i[n]   = $urandom;
                    end
                end else if (auto_rand && $urandom_range(3) == 0) begin
                    addr_i[n] = AW'($urandom_range(15));
                    be_i[n]   = BW'($urandom_range(15));
                    wd_i[n]   = $urandom;
                end
            end
        end
    end

    task automatic wait_done(input int n, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!done[n] && cyc < budget);
        checks++;
        if (!done[n]) begin
            errors++;
            $display("FAIL timeout m%0d: got no completion expected within %0d cycles", n, budget);
        end
    endtask

    task automatic op(input int n, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic [DW-1:0] d, output int cyc);
        addr_i[n] = a; be_i[n] = b; wd_i[n] = d; wr_i[n] = wr; rd_i[n] = !wr;
        wait_done(n, 20, cyc);
        rd_i[n] = 0; wr_i[n] = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic both_write(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bit got0, got1;
        int cyc;
        got0 = 0; got1 = 0; cyc = 0;
        addr_i[0] = a0; be_i[0] = 4'hF; wd_i[0] = 32'h0000_00A0; wr_i[0] = 1; rd_i[0] = 0;
        addr_i[1] = a1; be_i[1] = 4'hF; wd_i[1] = 32'h0000_00B1; wr_i[1] = 1; rd_i[1] = 0;
        while (!(got0 && got1) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (done[0]) begin got0 = 1; wr_i[0] = 0; end
            if (done[1]) begin got1 = 1; wr_i[1] = 0; end
        end
        checks++;
        if (!(got0 && got1)) begin
            errors++;
            $display("FAIL both_write timeout: got done %0d%0d expected 11", got0, got1);
        end
        wr_i[0] = 0; wr_i[1] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;
        for (int i = 0; i < 16384; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_rd = '0;
        for (int n = 0; n < 2; n++) begin
            addr_i[n] = '0; be_i[n] = '0; rd_i[n] = 0; wr_i[n] = 0; wd_i[n] = '0;
            auto_en[n] = 0; fix_addr[n] = '0; cap_rd[n] = '0;
        end
        auto_rand = 0;

        // Reset held with a pending write; the write lands two cycles after release
        reset_n = 0;
        addr_i[0] = 14'h0040; be_i[0] = 4'hF; wd_i[0] = 32'h1234_5678; wr_i[0] = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_m0_count", m0_count, 0);
        chk("rst_m1_count", m1_count, 0);
        reset_n = 1;
        wait_done(0, 10, c);
        wr_i[0] = 0;
        chk("rst_release_latency", c, 2);
        chk("rst_release_mem", ram_mem[14'h0040], 32'h1234_5678);

        // Single write then read
        do_reset();
        op(0, 1, 14'h0123, 4'hF, 32'hDEAD_BEEF, c);
        chk("write_latency", c, 2);
        op(0, 0, 14'h0123, 4'hF, 32'h0, c);
        chk("read_latency", c, 3);
        chk("read_data", cap_rd[0], 32'hDEAD_BEEF);
        chk("m0_count_after_2", m0_count, 2);

        // Byte lanes
        op(0, 1, 14'h0200, 4'hF, 32'hFFFF_FFFF, c);
        op(0, 1, 14'h0200, 4'h5, 32'h0000_0000, c);
        op(0, 0, 14'h0200, 4'hF, 32'h0, c);
        chk("byte_lane_readback", cap_rd[0], 32'hFF00_FF00);

        // Contention: continuous reads from both masters
        op(0, 1, 14'h0300, 4'hF, 32'hA0A0_A0A0, c);
        op(1, 1, 14'h0301, 4'hF, 32'hB1B1_B1B1, c);
        do_reset();
        grants.delete();
        fix_addr[0] = 14'h0300; fix_addr[1] = 14'h0301;
        @(negedge clk);
        auto_rand = 0; auto_en[0] = 1; auto_en[1] = 1;
        repeat (31) @(posedge clk);
        auto_en[0] = 0; auto_en[1] = 0;
        #1;
        rd_i[0] = 0; rd_i[1] = 0;
        chk("contention_grants", grants.size(), 10);
        chk("contention_g0", grants[0], 0);
        chk("contention_g1", grants[1], 1);
        chk("contention_g2", grants[2], 0);
        chk("contention_g3", grants[3], 1);
        chk("contention_m0_count", m0_count, 5);
        chk("contention_m1_count", m1_count, 5);
        chk("contention_m0_data", cap_rd[0], 32'hA0A0_A0A0);
        chk("contention_m1_data", cap_rd[1], 32'hB1B1_B1B1);
        repeat (3) @(posedge clk);

        // Last-served priority, both directions
        do_reset();
        op(1, 1, 14'h0500, 4'hF, 32'h1, c);
        grants.delete();
        both_write(14'h0501, 14'h0502);
        chk("last_served_m1_then_m0", grants[0], 0);
        chk("last_served_second", grants[1], 1);
        op(0, 1, 14'h0503, 4'hF, 32'h2, c);
        grants.delete();
        both_write(14'h0504, 14'h0505);
        chk("last_served_m0_then_m1", grants[0], 1);

        // Reset during the ACCESS cycle of a write drops it
        addr_i[0] = 14'h0400; be_i[0] = 4'hF; wd_i[0] = 32'hCAFE_F00D; wr_i[0] = 1;
        @(posedge clk); #1;
        chk("midreset_access_wait", m0_waitrequest, 0);
        chk("midreset_access_cs", ram_chipselect, 1);
        reset_n = 0; wr_i[0] = 0;
        @(posedge clk); #1;
        chk("midreset_mem_kept", ram_mem[14'h0400], 32'h0);
        chk("midreset_m0_wait", m0_waitrequest, 1);
        chk("midreset_cs", ram_chipselect, 0);
        chk("midreset_m0_count", m0_count, 0);
        chk("midreset_m1_count", m1_count, 0);
        reset_n = 1;

        // Random traffic with in-flight command changes, long enough to saturate counters
        do_reset();
        @(negedge clk);
        auto_rand = 1; auto_en[0] = 1; auto_en[1] = 1;
        repeat (5000) @(posedge clk);
        auto_en[0] = 0; auto_en[1] = 0;
        #1;
        for (int n = 0; n < 2; n++) begin rd_i[n] = 0; wr_i[n] = 0; end
        repeat (5) @(posedge clk);
        #1;
        chk("sat_m0_count", m0_count, CMAX);
        chk("sat_m1_count", m1_count, CMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
